// File: rtl/produto_escalar_csr.sv
// ----------------------------------------------------------------------------
// produto_escalar_csr
//
// Wishbone classic register front end and sequencer for the 8x32-bit signed
// dot-product unit. Holds both operand vectors, starts the unit with a single
// `iniciar_o` pulse, waits for `concluido_i` (or a timeout) and captures the
// 64-bit result.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i     Wishbone classic request
//   wb_adr_i[4:0]           word address
//   wb_dat_i/wb_dat_o       write data / registered read data
//   wb_ack_o                one-cycle acknowledge
//   irq_o                   level interrupt = done & irq_en
//   a0_o..a7_o, b0_o..b7_o  operand registers, driven continuously
//   iniciar_o               start pulse to the unit
//   resultado_i[63:0]       result from the unit
//   concluido_i             done level from the unit
//   dbg_state_o[1:0]        current sequencer state (0 IDLE, 1 PULSE, 2 ARM, 3 WAIT)
//
// Handshake: a request is taken when cyc&stb is high while ack is low; ack is
// raised on the next edge for exactly one cycle, writes commit on that edge and
// read data is valid while ack is high. A held request is thus served every
// other cycle.
//
// Register map: 0-7 A, 8-15 B, 16 CTRL{irq_en,start}, 17 STATUS{timeout,done,
// busy}, 18 RES_LO, 19 RES_HI, 20-31 read as zero.
// ----------------------------------------------------------------------------
module produto_escalar_csr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o,
    output logic [31:0] a0_o,
    output logic [31:0] a1_o,
    output logic [31:0] a2_o,
    output logic [31:0] a3_o,
    output logic [31:0] a4_o,
    output logic [31:0] a5_o,
    output logic [31:0] a6_o,
    output logic [31:0] a7_o,
    output logic [31:0] b0_o,
    output logic [31:0] b1_o,
    output logic [31:0] b2_o,
    output logic [31:0] b3_o,
    output logic [31:0] b4_o,
    output logic [31:0] b5_o,
    output logic [31:0] b6_o,
    output logic [31:0] b7_o,
    output logic        iniciar_o,
    input  logic [63:0] resultado_i,
    input  logic        concluido_i,
    output logic [1:0]  dbg_state_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] ADR_CTRL   = 5'd16;
    localparam logic [4:0] ADR_STATUS = 5'd17;
    localparam logic [4:0] ADR_RES_LO = 5'd18;
    localparam logic [4:0] ADR_RES_HI = 5'd19;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_ARM   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_a [8];
    logic [31:0]       r_b [8];
    logic [63:0]       r_res;
    logic              r_irq_en;
    logic              r_done;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ack;
    logic [31:0]       r_dat;

    logic              w_req;
    logic              w_wr;
    logic              w_busy;
    logic              w_start;
    logic              w_capture;
    logic              w_expire;
    logic              w_iniciar;
    logic [31:0]       w_rdata;

    // A new request is only taken while ack is low, giving one ack per two
    // cycles for a held strobe.
    assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr   = w_req & wb_we_i;
    assign w_busy = (r_state != S_IDLE);

    // start is honoured only when the sequencer was idle before this edge.
    assign w_start = w_wr && (wb_adr_i == ADR_CTRL) && wb_dat_i[0] && !w_busy;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_iniciar    = 1'b0;
        w_capture    = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next_state = S_PULSE;
            end
            S_PULSE: begin
                w_iniciar    = 1'b1;
                w_next_state = S_ARM;
            end
            S_ARM: begin
                // concluido_i may still be high from the previous run here.
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (concluido_i) begin
                    w_capture    = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_expire     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == S_ARM) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (w_wr && !w_busy && !wb_adr_i[4]) begin
            if (wb_adr_i[3]) r_b[wb_adr_i[2:0]] <= wb_dat_i;
            else             r_a[wb_adr_i[2:0]] <= wb_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_en <= 1'b0;
        end else if (w_wr && (wb_adr_i == ADR_CTRL)) begin
            r_irq_en <= wb_dat_i[1];
        end
    end

    // Sticky flags: a set on the same edge as a W1C wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_capture) begin
                r_done <= 1'b1;
            end else if (w_start) begin
                r_done <= 1'b0;
            end else if (w_wr && (wb_adr_i == ADR_STATUS) && wb_dat_i[1]) begin
                r_done <= 1'b0;
            end

            if (w_expire) begin
                r_timeout <= 1'b1;
            end else if (w_start) begin
                r_timeout <= 1'b0;
            end else if (w_wr && (wb_adr_i == ADR_STATUS) && wb_dat_i[2]) begin
                r_timeout <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_res <= '0;
        end else if (w_capture) begin
            r_res <= resultado_i;
        end
    end

    // ------------------------------------------------------------------
    // Bus read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (!wb_adr_i[4]) begin
            w_rdata = wb_adr_i[3] ? r_b[wb_adr_i[2:0]] : r_a[wb_adr_i[2:0]];
        end else begin
            case (wb_adr_i)
                ADR_CTRL:   w_rdata = {30'd0, r_irq_en, 1'b0};
                ADR_STATUS: w_rdata = {29'd0, r_timeout, r_done, w_busy};
                ADR_RES_LO: w_rdata = r_res[31:0];
                ADR_RES_HI: w_rdata = r_res[63:32];
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat;
    assign irq_o       = r_done & r_irq_en;
    assign iniciar_o   = w_iniciar;
    assign dbg_state_o = r_state;

    assign a0_o = r_a[0];
    assign a1_o = r_a[1];
    assign a2_o = r_a[2];
    assign a3_o = r_a[3];
    assign a4_o = r_a[4];
    assign a5_o = r_a[5];
    assign a6_o = r_a[6];
    assign a7_o = r_a[7];
    assign b0_o = r_b[0];
    assign b1_o = r_b[1];
    assign b2_o = r_b[2];
    assign b3_o = r_b[3];
    assign b4_o = r_b[4];
    assign b5_o = r_b[5];
    assign b6_o = r_b[6];
    assign b7_o = r_b[7];

endmodule
